// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
// Shared definitions for the multi-channel clock generator: channel state
// encoding and the default divider width / post-reset half-period.
// -----------------------------------------------------------------------------
package clk_gen_pkg;

    localparam int unsigned DIV_WIDTH_DEF  = 24;
    // 10 Hz at a 50 MHz clk_in: (2499999 + 1) cycles per half period.
    localparam int unsigned RESET_HALF_DEF = 2499999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } chan_state_e;

endpackage

// File: rtl/clk_gen_channel.sv
// -----------------------------------------------------------------------------
// clk_gen_channel
// One divider channel: 50 % duty divided clock with single-cycle rise/fall
// strobes, runtime half-period reload at phase boundaries and a clean stop
// that always finishes the current high phase.
//
// Ports:
//   clk_in      system clock (only clock)
//   reset       asynchronous active-low reset
//   enable      run request, level-sensitive
//   half_period half-period value; phase length = value+1 cycles
//   load        one-cycle strobe capturing half_period
//   clk_out     registered divided clock
//   rise_stb    high in the first cycle clk_out is high
//   fall_stb    high in the first cycle clk_out is low after a high phase
//   running     high while the channel is in RUN or STOP
//
// State | Meaning
// IDLE  | clk_out low, counter cleared, waiting for enable
// RUN   | dividing, enable present
// STOP  | dividing, enable withdrawn; finishes at the next phase boundary
// -----------------------------------------------------------------------------
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int unsigned RESET_HALF = RESET_HALF_DEF
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] half_period,
    input  logic                 load,
    output logic                 clk_out,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic                 running
);

    chan_state_e          state_q;
    logic                 en_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] active_half_q;
    logic [DIV_WIDTH-1:0] pending_half_q;
    logic                 pending_vld_q;
    logic                 clk_out_q;
    logic                 rise_stb_q;
    logic                 fall_stb_q;
    logic                 running_q;

    logic                 at_boundary_d;
    logic                 reload_take_d;
    logic [DIV_WIDTH-1:0] reload_val_d;
    logic [DIV_WIDTH-1:0] cnt_inc_d;

    always_comb begin
        at_boundary_d = (cnt_q == active_half_q);
        // A load arriving in the same cycle as a reload point bypasses the
        // pending register so the new value applies immediately.
        reload_take_d = load | pending_vld_q;
        reload_val_d  = load ? half_period : pending_half_q;
        cnt_inc_d     = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end

    // enable is registered before the FSM so no input reaches an output
    // without a flop, giving a start latency of two edges.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            en_q           <= 1'b0;
            cnt_q          <= '0;
            active_half_q  <= DIV_WIDTH'(RESET_HALF);
            pending_half_q <= '0;
            pending_vld_q  <= 1'b0;
            clk_out_q      <= 1'b0;
            rise_stb_q     <= 1'b0;
            fall_stb_q     <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            en_q       <= enable;
            rise_stb_q <= 1'b0;
            fall_stb_q <= 1'b0;

            if (load) begin
                pending_half_q <= half_period;
                pending_vld_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    if (reload_take_d) begin
                        active_half_q <= reload_val_d;
                        pending_vld_q <= 1'b0;
                    end
                    if (en_q) begin
                        clk_out_q  <= 1'b1;
                        rise_stb_q <= 1'b1;
                        running_q  <= 1'b1;
                        state_q    <= RUN;
                    end
                end

                RUN, STOP: begin
                    if (!at_boundary_d) begin
                        cnt_q   <= cnt_inc_d;
                        state_q <= en_q ? RUN : STOP;
                    end else begin
                        cnt_q <= '0;
                        if (reload_take_d) begin
                            active_half_q <= reload_val_d;
                            pending_vld_q <= 1'b0;
                        end
                        if (en_q) begin
                            clk_out_q  <= ~clk_out_q;
                            rise_stb_q <= ~clk_out_q;
                            fall_stb_q <= clk_out_q;
                            state_q    <= RUN;
                        end else begin
                            // Stop only on a boundary: a high phase ends with
                            // its normal fall, a low phase ends without a rise.
                            clk_out_q  <= 1'b0;
                            fall_stb_q <= clk_out_q;
                            running_q  <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out  = clk_out_q;
    assign rise_stb = rise_stb_q;
    assign fall_stb = fall_stb_q;
    assign running  = running_q;

endmodule

// File: rtl/clk_gen_multi.sv
// -----------------------------------------------------------------------------
// clk_gen_multi
// Multi-channel clock generator. Each channel is an independent divider; this
// level only slices the per-channel buses.
//
// Ports:
//   clk_in      system clock (only clock)
//   reset       asynchronous active-low reset
//   enable      per-channel run request
//   half_period channel k half-period at [k*DIV_WIDTH +: DIV_WIDTH]
//   load        per-channel half-period capture strobe
//   clk_out     per-channel divided clock
//   rise_stb    per-channel rising strobe
//   fall_stb    per-channel falling strobe
//   running     per-channel active indication
// -----------------------------------------------------------------------------
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int unsigned RESET_HALF = RESET_HALF_DEF
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS*DIV_WIDTH-1:0] half_period,
    input  logic [CHANNELS-1:0]           load,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [CHANNELS-1:0]           rise_stb,
    output logic [CHANNELS-1:0]           fall_stb,
    output logic [CHANNELS-1:0]           running
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        clk_gen_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .RESET_HALF (RESET_HALF)
        ) u_chan (
            .clk_in      (clk_in),
            .reset       (reset),
            .enable      (enable[k]),
            .half_period (half_period[k*DIV_WIDTH +: DIV_WIDTH]),
            .load        (load[k]),
            .clk_out     (clk_out[k]),
            .rise_stb    (rise_stb[k]),
            .fall_stb    (fall_stb[k]),
            .running     (running[k])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
module tb_clk_gen_multi;

    localparam int CH = 2;
    localparam int DW = 24;
    // Scaled-down post-reset half-period keeps the run short; phases are 50 cycles.
    localparam int TB_RESET_HALF = 49;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [CH-1:0]     enable;
    logic [CH*DW-1:0]  half_period;
    logic [CH-1:0]     load;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     rise_stb;
    logic [CH-1:0]     fall_stb;
    logic [CH-1:0]     running;

    clk_gen_multi #(
        .CHANNELS   (CH),
        .DIV_WIDTH  (DW),
        .RESET_HALF (TB_RESET_HALF)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .half_period (half_period),
        .load        (load),
        .clk_out     (clk_out),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .running     (running)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected phase lengths per channel, pushed by stimulus, popped by monitor.
    int exp_q[CH][$];

    logic [CH-1:0] prev_clk;
    logic [CH-1:0] prev_run;
    logic [CH-1:0] ph_valid;
    int            ph_len[CH];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor_step();
        for (int c = 0; c < CH; c++) begin
            if (!reset) begin
                prev_clk[c] = 1'b0;
                prev_run[c] = 1'b0;
                ph_valid[c] = 1'b0;
                ph_len[c]   = 0;
            end else begin
                logic trans;
                logic run_fell;
                trans    = (clk_out[c] != prev_clk[c]);
                run_fell = prev_run[c] && !running[c] && !trans;
                check_val($sformatf("ch%0d_rise_stb", c), rise_stb[c], clk_out[c] && !prev_clk[c]);
                check_val($sformatf("ch%0d_fall_stb", c), fall_stb[c], !clk_out[c] && prev_clk[c]);
                if (trans || run_fell) begin
                    if (ph_valid[c] && exp_q[c].size() > 0)
                        check_val($sformatf("ch%0d_phase_len", c), ph_len[c], exp_q[c].pop_front());
                    ph_len[c]   = 1;
                    ph_valid[c] = running[c];
                end else begin
                    ph_len[c]++;
                    if (!running[c]) ph_valid[c] = 1'b0;
                end
                prev_clk[c] = clk_out[c];
                prev_run[c] = running[c];
            end
        end
    endtask

    // All time advance goes through here: monitor on the falling edge, then
    // stimulus and direct checks 1 time unit later.
    task automatic tick();
        @(negedge clk_in);
        monitor_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_phases(input int ch, input int len, input int n);
        for (int i = 0; i < n; i++) exp_q[ch].push_back(len);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            tick();
        end
        check_val("sb_drain", exp_q[0].size() + exp_q[1].size(), 0);
        exp_q[0].delete();
        exp_q[1].delete();
    endtask

    task automatic wait_rise(input int ch, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (clk_out[ch] && rise_stb[ch]) begin
                found = 1'b1;
                break;
            end
        end
        check_val($sformatf("ch%0d_rise_seen", ch), found, 1);
    endtask

    task automatic reset_dut();
        reset       = 1'b0;
        enable      = '0;
        load        = '0;
        half_period = '0;
        ticks(3);
        reset = 1'b1;
        tick();
    endtask

    task automatic set_half(input int ch, input int val);
        half_period[ch*DW +: DW] = DW'(val);
        load[ch] = 1'b1;
        tick();
        load[ch] = 1'b0;
    endtask

    task automatic check_quiet(input int ch, input int n);
        logic saw_high;
        saw_high = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (clk_out[ch] || running[ch]) saw_high = 1'b1;
        end
        check_val($sformatf("ch%0d_quiet_after_stop", ch), saw_high, 0);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 2'b01;
        load        = '0;
        half_period = '0;

        // Reset state, start latency, post-reset half-period.
        ticks(3);
        check_val("rst_clk_out", clk_out, 0);
        check_val("rst_running", running, 0);
        check_val("rst_strobes", {rise_stb, fall_stb}, 0);
        reset = 1'b1;
        push_phases(0, TB_RESET_HALF + 1, 4);
        tick();
        check_val("start_lat_n", clk_out[0], 0);
        tick();
        check_val("start_lat_clk", clk_out[0], 1);
        check_val("start_lat_rise", rise_stb[0], 1);
        check_val("ch1_idle_clk", clk_out[1], 0);
        check_val("ch1_idle_run", running[1], 0);
        wait_drain(400);

        // Half-period 0: toggle every cycle.
        reset_dut();
        set_half(0, 0);
        enable[0] = 1'b1;
        push_phases(0, 1, 8);
        wait_drain(50);
        check_val("div2_strobe_alt", rise_stb[0] ^ fall_stb[0], 1);

        // Load mid-phase: current phase unchanged, later phases use new value.
        reset_dut();
        set_half(0, 3);
        enable[0] = 1'b1;
        wait_rise(0, 20);
        tick();
        half_period[0 +: DW] = DW'(7);
        load[0] = 1'b1;
        push_phases(0, 4, 1);
        push_phases(0, 8, 3);
        tick();
        load[0] = 1'b0;
        wait_drain(60);

        // Load coinciding with a boundary: bypass applies from that boundary.
        reset_dut();
        set_half(0, 3);
        enable[0] = 1'b1;
        wait_rise(0, 20);
        push_phases(0, 4, 1);
        push_phases(0, 8, 2);
        ticks(3);
        half_period[0 +: DW] = DW'(7);
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        wait_drain(60);

        // Stop during high phase: high completes, fall, idle, no further rise.
        reset_dut();
        set_half(0, 9);
        enable[0] = 1'b1;
        wait_rise(0, 20);
        push_phases(0, 10, 1);
        ticks(2);
        enable[0] = 1'b0;
        wait_drain(40);
        check_val("stop_hi_fall", fall_stb[0], 1);
        check_val("stop_hi_run", running[0], 0);
        check_val("stop_hi_clk", clk_out[0], 0);
        check_quiet(0, 25);

        // Stop during low phase: low completes with no rise.
        reset_dut();
        set_half(0, 9);
        enable[0] = 1'b1;
        wait_rise(0, 20);
        push_phases(0, 10, 2);
        ticks(13);
        enable[0] = 1'b0;
        wait_drain(40);
        check_val("stop_lo_run", running[0], 0);
        check_val("stop_lo_fall", fall_stb[0], 0);
        check_quiet(0, 25);

        // Re-enable during STOP: waveform continues unbroken.
        reset_dut();
        set_half(0, 9);
        enable[0] = 1'b1;
        wait_rise(0, 20);
        push_phases(0, 10, 4);
        ticks(3);
        enable[0] = 1'b0;
        ticks(3);
        check_val("stop_state_run", running[0], 1);
        enable[0] = 1'b1;
        wait_drain(80);
        check_val("resume_run", running[0], 1);

        // Async reset mid-high on both channels, then reset half-period on ch1.
        reset_dut();
        set_half(0, 4);
        set_half(1, 1);
        enable = 2'b11;
        wait_rise(0, 20);
        check_val("both_high", clk_out, 2'b11);
        reset = 1'b0;
        #1;
        check_val("async_rst_clk", clk_out, 0);
        check_val("async_rst_run", running, 0);
        ticks(2);
        enable = 2'b10;
        reset  = 1'b1;
        push_phases(1, TB_RESET_HALF + 1, 2);
        wait_drain(300);

        // Concurrent independent channels: periods 10 and 4.
        reset_dut();
        set_half(0, 4);
        set_half(1, 1);
        enable = 2'b11;
        push_phases(0, 5, 4);
        push_phases(1, 2, 10);
        wait_drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen_multi.md
# clk_gen_multi

Parametrised multi-channel clock generator; successor to the single fixed-pair divider in the executor.
- Each channel produces a divided 50 % duty clock plus single-cycle rise and fall strobes, all derived from `clk_in`.
- Each channel has a runtime-programmable half-period, a glitch-free reload and a clean start/stop that never emits a runt pulse.
- Feeds the TCK generator (variable rate) and slow housekeeping ticks (10 Hz LED/watchdog) from one block, with no derived-clock always blocks.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent divider channels.
- `DIV_WIDTH`, 24, width of the half-period count per channel.
- `RESET_HALF`, 2499999, active half-period value after reset; gives 10 Hz at 50 MHz `clk_in`.

Ports:
- `clk_in`  in  1  system clock; the only clock, and every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low; all state clears immediately on assertion.
- `enable`  in  CHANNELS  per-channel run request, level-sensitive.
- `half_period`  in  CHANNELS*DIV_WIDTH  channel k value at `[k*DIV_WIDTH +: DIV_WIDTH]`; half-period = value+1 `clk_in` cycles.
- `load`  in  CHANNELS  one-cycle strobe; captures that channel's `half_period`.
- `clk_out`  out  CHANNELS  registered divided clock.
- `rise_stb`  out  CHANNELS  1 during the first cycle `clk_out` is high.
- `fall_stb`  out  CHANNELS  1 during the first cycle `clk_out` is low after a high phase.
- `running`  out  CHANNELS  1 while the channel is in state RUN or STOP.

## Operation
Registers per channel:
- `cnt` (DIV_WIDTH).
- `active_half` (DIV_WIDTH).
- `pending_half` (DIV_WIDTH) and `pending_vld`.
- `clk_out`, `rise_stb`, `fall_stb`, state.

States:
- IDLE: `clk_out`=0, `cnt`=0. If `enable`=1: `clk_out`<=1, `rise_stb`<=1, `cnt`<=0, go to RUN.
- RUN:
  - If `cnt` != `active_half`: `cnt`++.
  - Else (boundary): `cnt`<=0 and `clk_out` toggles, with the matching strobe.
  - If `enable`=0 at a boundary while `clk_out`=1: toggle low, `fall_stb`=1, go to IDLE.
  - If `enable`=0 at a boundary while `clk_out`=0: no toggle, go to IDLE.
  - If `enable`=0 mid-half-period: go to STOP.
- STOP: counts like RUN; at the next boundary it completes the low phase exactly as above and goes to IDLE. If `enable` returns to 1 in STOP, go back to RUN with no disturbance to the waveform.

Reload:
- `load`=1 sets `pending_half`<=`half_period` and `pending_vld`<=1.
- At a boundary, or in IDLE, `active_half`<=`pending_half` and `pending_vld`<=0.
- If `load` and a boundary coincide, the new value applies at that boundary (bypass).
- In IDLE, a `load` takes effect on the next cycle.

Arithmetic:
- `cnt` compares equal only and never wraps past `active_half`.
- A value of 0 gives toggling every cycle (`clk_in`/2).
- All-ones is the slowest rate: 2^DIV_WIDTH cycles per half.

Channels are fully independent; no cross-channel phase relation is guaranteed.

## Timing
- Reset values: `clk_out`, `rise_stb`, `fall_stb`, `running` = 0; state IDLE; `cnt`=0; `active_half`=`RESET_HALF`; `pending_vld`=0.
- Start latency: `enable` sampled high at edge N gives `clk_out`=1 and `rise_stb`=1 after edge N+1. No combinational path from any input to any output.
- Each phase lasts exactly `active_half`+1 cycles; period = 2*(`active_half`+1).
- Strobes are exactly 1 cycle wide and coincide with the `clk_out` transition cycle.
- Stop: the final high phase always completes at full length; `running` falls in the same cycle `clk_out` is low and the state reaches IDLE.
- Reset asserted mid-operation: outputs go to 0 asynchronously and a truncated pulse is acceptable. After reset release, outputs stay 0 until `enable` is sampled.

## Structure
- Package `clk_gen_pkg`: holds the channel state enum (IDLE, RUN, STOP) and the `DIV_WIDTH` and `RESET_HALF` defaults.
- Sub-module `clk_gen_channel`: one channel, instantiated `CHANNELS` times by generate. The top level only slices the buses.

## Test plan
- Reset release with `enable`=1 on ch0, no load → `clk_out` period 5000000 cycles, first rise 1 cycle after enable sampled, strobes 1 cycle wide.
- Load 0 then `enable` → `clk_out` toggles every cycle; `rise_stb` and `fall_stb` alternate every cycle; period 2 cycles.
- Running at half=3, load 7 mid-phase → current phase stays 4 cycles, next phases 8 cycles. Load coinciding with a boundary → 8 cycles from that boundary.
- Half=9, drop `enable` 2 cycles into the high phase → high lasts 10 cycles, then `fall_stb`, `running`=0, no further rise.
- Drop `enable` during the low phase → low completes 10 cycles with no rise.
- Re-raise `enable` during STOP → waveform continues unbroken.
- Assert `reset` mid-high on both channels → `clk_out`=0 immediately and `active_half`=`RESET_HALF`. Ch1 at half=1 and ch0 at half=4 run concurrently with independent periods 4 and 10.
